// File: rtl/ibus_resp_mem_pkg.sv
// Shared ibus constants and RAM-port grant encoding for the ibus responder memory.
package ibus_resp_mem_pkg;

    localparam int IBUS_ADR_MSB = 19;
    localparam int IBUS_ADR_LSB = 2;
    localparam int IBUS_DW      = 16;
    localparam int ERR_CNT_W    = 16;

    // Owner of the single RAM port in a given cycle.
    typedef enum logic [1:0] {
        RAM_IDLE    = 2'd0,
        RAM_IBUS_RD = 2'd1,
        RAM_DRAIN   = 2'd2,
        RAM_LCL_RD  = 2'd3
    } ram_gnt_e;

endpackage

// File: rtl/ibus_resp_mem_wbuf.sv
// Posted-write FIFO for the ibus responder: stores {index,data}, exposes the head entry
// for draining and a youngest-match forwarding lookup for reads.
module ibus_resp_mem_wbuf #(
    parameter int AWIDTH = 12,
    parameter int DEPTH  = 4,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [AWIDTH-1:0] push_idx,
    input  logic [DW-1:0]     push_data,
    input  logic              pop,
    output logic [AWIDTH-1:0] head_idx,
    output logic [DW-1:0]     head_data,
    input  logic [AWIDTH-1:0] lookup_idx,
    output logic              fwd_hit,
    output logic [DW-1:0]     fwd_data,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);

    logic [AWIDTH-1:0] idx_mem [DEPTH];
    logic [DW-1:0]     dat_mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic [PW:0]       count_nxt;
    logic              full_q;
    logic              push_ok;
    logic              pop_ok;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && (!full_q || pop_ok);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok)
            count_nxt = count + 1'b1;
        else if (!push_ok && pop_ok)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count  <= count_nxt;
            full_q <= (count_nxt == (PW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            idx_mem[wr_ptr] <= push_idx;
            dat_mem[wr_ptr] <= push_data;
        end
    end

    assign head_idx  = idx_mem[rd_ptr];
    assign head_data = dat_mem[rd_ptr];
    assign full      = full_q;
    assign empty     = (count == '0);

    // Walk oldest to youngest so the last match found is the newest posted value.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (((PW+1)'(k) < count) && (idx_mem[rd_ptr + PW'(k)] == lookup_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = dat_mem[rd_ptr + PW'(k)];
            end
        end
    end

endmodule

// File: rtl/ibus_resp_mem.sv
// DMA ibus responder: posted writes into a local 16-bit RAM, one-cycle ibus reads, local read port.
// Build option: IBUS_RESP_ERRCNT_EN enables the saturating ibus_err pulse counter on err_cnt.
module ibus_resp_mem
    import ibus_resp_mem_pkg::*;
#(
    parameter int AWIDTH     = 12,
    parameter int BASE_TAG   = 0,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ibus_ren,
    input  logic [IBUS_ADR_MSB:IBUS_ADR_LSB]   ibus_radr,
    output logic [IBUS_DW-1:0]                 ibus32_rdata,
    input  logic                               ibus_wen,
    input  logic [IBUS_ADR_MSB:IBUS_ADR_LSB]   ibus_wadr,
    input  logic [IBUS_DW-1:0]                 ibus32_wdata,
    input  logic                               lcl_ren,
    input  logic [AWIDTH-1:0]                  lcl_radr,
    output logic [IBUS_DW-1:0]                 lcl_rdata,
    output logic                               lcl_rvalid,
    output logic                               wbuf_full,
    output logic                               ibus_err,
    output logic [ERR_CNT_W-1:0]               err_cnt
);

    localparam int IDX_LSB = IBUS_ADR_LSB;
    localparam int TAG_LSB = AWIDTH + IBUS_ADR_LSB;
    localparam int TAG_W   = IBUS_ADR_MSB - TAG_LSB + 1;
    localparam logic [TAG_W-1:0] TAG = TAG_W'(BASE_TAG);

    logic [IBUS_DW-1:0] mem [2**AWIDTH];
    logic [IBUS_DW-1:0] ram_q;

    logic               rd_hit;
    logic               wr_hit;
    logic [AWIDTH-1:0]  rd_idx;
    logic [AWIDTH-1:0]  wr_idx;
    logic               rd_req;
    logic               wr_req;
    logic               wb_push;
    logic               wb_pop;
    logic               wb_full;
    logic               wb_empty;
    logic               wb_fwd_hit;
    logic [IBUS_DW-1:0] wb_fwd_data;
    logic [AWIDTH-1:0]  wb_head_idx;
    logic [IBUS_DW-1:0] wb_head_data;
    logic               wr_drop;
    logic               err_nxt;
    logic               same_fwd;
    logic               lcl_gnt;
    ram_gnt_e           gnt;
    logic [AWIDTH-1:0]  ram_adr;

    logic               rd_vld_p1;
    logic               rd_map_p1;
    logic               fwd_sel_p1;
    logic [IBUS_DW-1:0] fwd_data_p1;
    logic [IBUS_DW-1:0] rd_data_p1;
    logic [IBUS_DW-1:0] rdata_hold;

    // ---- Stage p0: decode, forwarding and RAM port arbitration ----
    assign rd_hit = (ibus_radr[IBUS_ADR_MSB:TAG_LSB] == TAG);
    assign wr_hit = (ibus_wadr[IBUS_ADR_MSB:TAG_LSB] == TAG);
    assign rd_idx = ibus_radr[TAG_LSB-1:IDX_LSB];
    assign wr_idx = ibus_wadr[TAG_LSB-1:IDX_LSB];

    assign rd_req   = ibus_ren && rd_hit;
    assign wr_req   = ibus_wen && wr_hit;
    assign wb_pop   = !wb_empty && !rd_req;
    assign wb_push  = wr_req && (!wb_full || wb_pop);
    assign wr_drop  = wr_req && wb_full && !wb_pop;
    assign err_nxt  = (ibus_ren && !rd_hit) || (ibus_wen && !wr_hit) || wr_drop;
    assign same_fwd = wr_req && (wr_idx == rd_idx);

    // Local reads wait for an empty wbuf, so they never need forwarding to stay coherent.
    assign lcl_gnt = lcl_ren && !lcl_rvalid && !rd_req && wb_empty;

    ibus_resp_mem_wbuf #(
        .AWIDTH (AWIDTH),
        .DEPTH  (WBUF_DEPTH),
        .DW     (IBUS_DW)
    ) u_wbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (wb_push),
        .push_idx   (wr_idx),
        .push_data  (ibus32_wdata),
        .pop        (wb_pop),
        .head_idx   (wb_head_idx),
        .head_data  (wb_head_data),
        .lookup_idx (rd_idx),
        .fwd_hit    (wb_fwd_hit),
        .fwd_data   (wb_fwd_data),
        .full       (wb_full),
        .empty      (wb_empty)
    );

    always_comb begin
        gnt = RAM_IDLE;
        if (rd_req)
            gnt = RAM_IBUS_RD;
        else if (wb_pop)
            gnt = RAM_DRAIN;
        else if (lcl_gnt)
            gnt = RAM_LCL_RD;
    end

    always_comb begin
        ram_adr = rd_idx;
        case (gnt)
            RAM_DRAIN:  ram_adr = wb_head_idx;
            RAM_LCL_RD: ram_adr = lcl_radr;
            default:    ram_adr = rd_idx;
        endcase
    end

    always_ff @(posedge clk) begin
        if (gnt == RAM_DRAIN)
            mem[ram_adr] <= wb_head_data;
        if (gnt == RAM_IBUS_RD || gnt == RAM_LCL_RD)
            ram_q <= mem[ram_adr];
    end

    // ---- Stage p1: read-data select, hold register and error pulse ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p1  <= 1'b0;
            rd_map_p1  <= 1'b0;
            fwd_sel_p1 <= 1'b0;
            lcl_rvalid <= 1'b0;
            ibus_err   <= 1'b0;
            rdata_hold <= '0;
        end else begin
            rd_vld_p1  <= ibus_ren;
            rd_map_p1  <= rd_hit;
            fwd_sel_p1 <= same_fwd || wb_fwd_hit;
            lcl_rvalid <= lcl_gnt;
            ibus_err   <= err_nxt;
            if (rd_vld_p1)
                rdata_hold <= rd_data_p1;
        end
    end

    always_ff @(posedge clk) begin
        fwd_data_p1 <= same_fwd ? ibus32_wdata : wb_fwd_data;
    end

    always_comb begin
        rd_data_p1 = ram_q;
        if (!rd_map_p1)
            rd_data_p1 = '0;
        else if (fwd_sel_p1)
            rd_data_p1 = fwd_data_p1;
    end

    assign ibus32_rdata = rd_vld_p1 ? rd_data_p1 : rdata_hold;
    assign lcl_rdata    = lcl_rvalid ? ram_q : '0;
    assign wbuf_full    = wb_full;

`ifdef IBUS_RESP_ERRCNT_EN
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_q <= '0;
        else if (ibus_err)
            err_cnt_q <= sat_inc(err_cnt_q);
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ibus_resp_mem.sv
// Directed self-checking bench for ibus_resp_mem (default parameters, AWIDTH=12, WBUF_DEPTH=4).
module tb_ibus_resp_mem;

    logic        clk;
    logic        rst_n;
    logic        ibus_ren;
    logic [19:2] ibus_radr;
    logic [15:0] ibus32_rdata;
    logic        ibus_wen;
    logic [19:2] ibus_wadr;
    logic [15:0] ibus32_wdata;
    logic        lcl_ren;
    logic [11:0] lcl_radr;
    logic [15:0] lcl_rdata;
    logic        lcl_rvalid;
    logic        wbuf_full;
    logic        ibus_err;
    logic [15:0] err_cnt;

    int n_cmp;
    int n_bad;
    int exp_errs;

    ibus_resp_mem dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ibus_ren     (ibus_ren),
        .ibus_radr    (ibus_radr),
        .ibus32_rdata (ibus32_rdata),
        .ibus_wen     (ibus_wen),
        .ibus_wadr    (ibus_wadr),
        .ibus32_wdata (ibus32_wdata),
        .lcl_ren      (lcl_ren),
        .lcl_radr     (lcl_radr),
        .lcl_rdata    (lcl_rdata),
        .lcl_rvalid   (lcl_rvalid),
        .wbuf_full    (wbuf_full),
        .ibus_err     (ibus_err),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_cnt();
`ifdef IBUS_RESP_ERRCNT_EN
        return 16'(exp_errs);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic ibus_read(input logic [19:2] adr);
        ibus_ren = 1'b1; ibus_radr = adr;
        cyc();
        ibus_ren = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ibus_ren = 1'b0; ibus_wen = 1'b0; lcl_ren = 1'b0;
        ibus_radr = '0; ibus_wadr = '0; ibus32_wdata = '0; lcl_radr = '0;
        cyc(); cyc();
        n_cmp++; if (ibus32_rdata !== 16'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0000", ibus32_rdata); end
        n_cmp++; if (lcl_rdata !== 16'h0) begin n_bad++; $display("FAIL reset_lcl_rdata: got %h want 0000", lcl_rdata); end
        n_cmp++; if (lcl_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_lcl_rvalid: got %b want 0", lcl_rvalid); end
        n_cmp++; if (ibus_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", ibus_err); end
        n_cmp++; if (err_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_err_cnt: got %h want 0000", err_cnt); end
        n_cmp++; if (wbuf_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", wbuf_full); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_write_read();
        ibus_wen = 1'b1; ibus_wadr = 18'h10; ibus32_wdata = 16'hBEEF;
        cyc();
        ibus_wen = 1'b0;
        cyc(); cyc(); cyc();
        ibus_read(18'h10);
        n_cmp++; if (ibus32_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL wr_rd_data: got %h want beef", ibus32_rdata); end
        n_cmp++; if (ibus_err !== 1'b0) begin n_bad++; $display("FAIL wr_rd_err: got %b want 0", ibus_err); end
        cyc();
        n_cmp++; if (ibus32_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL wr_rd_hold: got %h want beef", ibus32_rdata); end
    endtask

    task automatic test_same_cycle_fwd();
        ibus_wen = 1'b1; ibus_wadr = 18'h20; ibus32_wdata = 16'h1234;
        ibus_ren = 1'b1; ibus_radr = 18'h20;
        cyc();
        ibus_wen = 1'b0; ibus_ren = 1'b0;
        n_cmp++; if (ibus32_rdata !== 16'h1234) begin n_bad++; $display("FAIL same_fwd_data: got %h want 1234", ibus32_rdata); end
        cyc(); cyc(); cyc();
        ibus_read(18'h20);
        n_cmp++; if (ibus32_rdata !== 16'h1234) begin n_bad++; $display("FAIL same_fwd_ram: got %h want 1234", ibus32_rdata); end
    endtask

    task automatic test_wbuf_fwd();
        ibus_ren = 1'b1; ibus_radr = 18'h10;
        ibus_wen = 1'b1; ibus_wadr = 18'h40; ibus32_wdata = 16'hAAAA;
        cyc();
        ibus32_wdata = 16'hBBBB;
        cyc();
        ibus_wen = 1'b0;
        n_cmp++; if (ibus32_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL wbuf_fwd_other: got %h want beef", ibus32_rdata); end
        ibus_radr = 18'h40;
        cyc();
        ibus_ren = 1'b0;
        n_cmp++; if (ibus32_rdata !== 16'hBBBB) begin n_bad++; $display("FAIL wbuf_fwd_youngest: got %h want bbbb", ibus32_rdata); end
        cyc(); cyc(); cyc();
        ibus_read(18'h40);
        n_cmp++; if (ibus32_rdata !== 16'hBBBB) begin n_bad++; $display("FAIL wbuf_fwd_drained: got %h want bbbb", ibus32_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] wadr_tab [5];
        logic [15:0] wdat_tab [5];
        wadr_tab = '{18'h50, 18'h51, 18'h52, 18'h53, 18'h50};
        wdat_tab = '{16'h5000, 16'h5001, 16'h5002, 16'h5003, 16'h5FFF};
        ibus_ren = 1'b1; ibus_radr = 18'h10;
        for (int i = 0; i < 5; i++) begin
            ibus_wen = 1'b1; ibus_wadr = wadr_tab[i]; ibus32_wdata = wdat_tab[i];
            cyc();
            n_cmp++; if (ibus_err !== (i == 4)) begin n_bad++; $display("FAIL b2b_err[%0d]: got %b want %b", i, ibus_err, (i == 4)); end
            n_cmp++; if (wbuf_full !== (i >= 3)) begin n_bad++; $display("FAIL b2b_full[%0d]: got %b want %b", i, wbuf_full, (i >= 3)); end
        end
        exp_errs++;
        ibus_wen = 1'b0;
        cyc();
        n_cmp++; if (ibus_err !== 1'b0) begin n_bad++; $display("FAIL b2b_err_single: got %b want 0", ibus_err); end
        n_cmp++; if (err_cnt !== exp_cnt()) begin n_bad++; $display("FAIL b2b_err_cnt: got %h want %h", err_cnt, exp_cnt()); end
        ibus_ren = 1'b0;
        cyc();
        n_cmp++; if (wbuf_full !== 1'b0) begin n_bad++; $display("FAIL b2b_full_clear: got %b want 0", wbuf_full); end
        cyc(); cyc(); cyc(); cyc();
        ibus_read(18'h50);
        n_cmp++; if (ibus32_rdata !== 16'h5000) begin n_bad++; $display("FAIL b2b_dropped: got %h want 5000", ibus32_rdata); end
    endtask

    task automatic test_unmapped();
        logic [19:2] bad;
        bad = 18'h10;
        bad[19:14] = 6'h01;
        ibus_read(bad);
        exp_errs++;
        n_cmp++; if (ibus32_rdata !== 16'h0000) begin n_bad++; $display("FAIL unmap_rdata: got %h want 0000", ibus32_rdata); end
        n_cmp++; if (ibus_err !== 1'b1) begin n_bad++; $display("FAIL unmap_rd_err: got %b want 1", ibus_err); end
        bad[19:14] = 6'h02;
        ibus_wen = 1'b1; ibus_wadr = bad; ibus32_wdata = 16'hDEAD;
        cyc();
        ibus_wen = 1'b0;
        exp_errs++;
        n_cmp++; if (ibus_err !== 1'b1) begin n_bad++; $display("FAIL unmap_wr_err: got %b want 1", ibus_err); end
        cyc(); cyc();
        ibus_read(18'h10);
        n_cmp++; if (ibus32_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL unmap_ram_kept: got %h want beef", ibus32_rdata); end
        n_cmp++; if (err_cnt !== exp_cnt()) begin n_bad++; $display("FAIL unmap_err_cnt: got %h want %h", err_cnt, exp_cnt()); end
    endtask

    task automatic test_local_read();
        int waited;
        ibus_ren = 1'b1; ibus_radr = 18'h10;
        for (int i = 0; i < 3; i++) begin
            ibus_wen = 1'b1; ibus_wadr = 18'h30; ibus32_wdata = 16'hC001 + 16'(i);
            cyc();
        end
        ibus_wen = 1'b0;
        lcl_ren = 1'b1; lcl_radr = 12'h030;
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_cmp++; if (lcl_rvalid !== 1'b0) begin n_bad++; $display("FAIL lcl_blocked[%0d]: got %b want 0", i, lcl_rvalid); end
        end
        ibus_ren = 1'b0;
        waited = 0;
        while (waited < 20) begin
            cyc();
            waited++;
            if (lcl_rvalid === 1'b1) break;
        end
        lcl_ren = 1'b0;
        n_cmp++; if (lcl_rvalid !== 1'b1) begin n_bad++; $display("FAIL lcl_timeout: got %b want 1 within 20 cycles", lcl_rvalid); end
        n_cmp++; if (waited != 4) begin n_bad++; $display("FAIL lcl_latency: got %0d want 4 cycles", waited); end
        n_cmp++; if (lcl_rdata !== 16'hC003) begin n_bad++; $display("FAIL lcl_data: got %h want c003", lcl_rdata); end
        cyc();
        n_cmp++; if (lcl_rvalid !== 1'b0) begin n_bad++; $display("FAIL lcl_pulse: got %b want 0", lcl_rvalid); end
    endtask

    task automatic test_reset_mid();
        ibus_wen = 1'b1; ibus_wadr = 18'h60; ibus32_wdata = 16'h6060;
        cyc();
        ibus_wadr = 18'h61; ibus32_wdata = 16'h6161;
        cyc();
        ibus_wen = 1'b0;
        cyc(); cyc(); cyc();
        ibus_ren = 1'b1; ibus_radr = 18'h10;
        ibus_wen = 1'b1; ibus_wadr = 18'h60; ibus32_wdata = 16'hAAAA;
        cyc();
        ibus_wadr = 18'h61; ibus32_wdata = 16'hBBBB;
        cyc();
        ibus_wen = 1'b0;
        n_cmp++; if (ibus32_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL rstmid_pre: got %h want beef", ibus32_rdata); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (ibus32_rdata !== 16'h0) begin n_bad++; $display("FAIL rstmid_rdata: got %h want 0000", ibus32_rdata); end
        n_cmp++; if (wbuf_full !== 1'b0 || ibus_err !== 1'b0 || lcl_rvalid !== 1'b0) begin n_bad++; $display("FAIL rstmid_ctrl: got full=%b err=%b rvalid=%b want 0 0 0", wbuf_full, ibus_err, lcl_rvalid); end
        n_cmp++; if (err_cnt !== 16'h0) begin n_bad++; $display("FAIL rstmid_err_cnt: got %h want 0000", err_cnt); end
        ibus_ren = 1'b0;
        exp_errs = 0;
        cyc();
        rst_n = 1'b1;
        cyc(); cyc(); cyc();
        ibus_read(18'h60);
        n_cmp++; if (ibus32_rdata !== 16'h6060) begin n_bad++; $display("FAIL rstmid_ram60: got %h want 6060", ibus32_rdata); end
        ibus_read(18'h61);
        n_cmp++; if (ibus32_rdata !== 16'h6161) begin n_bad++; $display("FAIL rstmid_ram61: got %h want 6161", ibus32_rdata); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_errs = 0;
        test_reset();
        test_write_read();
        test_same_cycle_fwd();
        test_wbuf_fwd();
        test_back_to_back();
        test_unmapped();
        test_local_read();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
